hex_scan_driver: RTL

- Multiplexed scan driver that sits directly upstream of the hex-to-7-segment decoder.
- Holds a multi-digit hex value and cycles through the digits one at a time.
- Presents the current digit's nibble on c3..c0 to the decoder and drives one-hot digit enables for the common-anode/cathode select.
- Inserts a short all-off gap between digits to prevent ghosting. New values are taken only at frame boundaries, so the display never tears.

---
 rtl/hex_scan_driver.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/hex_scan_driver.sv
// -----------------------------------------------------------------------------
// hex_scan_driver
//
// Multiplexed scan driver for a multi-digit hex display. It holds a shadow copy
// of the displayed value and walks the digits one at a time. Each digit slot is
// BLANK_GAP cycles with every enable off (anti-ghosting), then PRESCALE cycles
// with that digit's enable on. The current nibble goes to a downstream
// hex-to-7-segment decoder on c3..c0. New values are double-buffered: load
// fills a pending buffer, and the shadow is only replaced at the end of a
// frame, so a frame never shows a mix of old and new digits.
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous, active-high reset
//   load        one-cycle strobe: capture value/dp_in into the pending buffer
//   value       hex value, nibble i (bits 4i+3..4i) is digit i, digit 0 rightmost
//   dp_in       decimal-point request per digit, captured with value
//   lz_blank    level: blank leading zero digits (digit 0 is never blanked)
//   c3..c0      current digit nibble to the decoder, c3 = MSB
//   dig_en      one-hot active-high digit enable, zero in gaps and blanked slots
//   dp          decimal point for the currently lit digit
//   frame_done  one-cycle pulse on the last cycle of each frame
//   pending     a loaded value is waiting for the next frame boundary
// -----------------------------------------------------------------------------
module hex_scan_driver #(
    parameter int DIGITS    = 4,
    parameter int PRESCALE  = 1000,
    parameter int BLANK_GAP = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  lz_blank,
    output logic                  c3,
    output logic                  c2,
    output logic                  c1,
    output logic                  c0,
    output logic [DIGITS-1:0]     dig_en,
    output logic                  dp,
    output logic                  frame_done,
    output logic                  pending
);

    localparam int IDX_W   = $clog2(DIGITS);
    localparam int CNT_MAX = (PRESCALE > BLANK_GAP) ? PRESCALE : BLANK_GAP;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(BLANK_GAP - 1);
    localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(PRESCALE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);

    typedef enum logic {
        ST_GAP  = 1'b0,
        ST_SHOW = 1'b1
    } state_e;

    // Scan state
    state_e               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    // Displayed (shadow) and waiting (pending) copies of value/dp
    logic [4*DIGITS-1:0]  shadow_q, shadow_d;
    logic [DIGITS-1:0]    shadow_dp_q, shadow_dp_d;
    logic [4*DIGITS-1:0]  buf_q, buf_d;
    logic [DIGITS-1:0]    buf_dp_q, buf_dp_d;
    logic                 pending_q, pending_d;

    // Output registers
    logic [3:0]           nib_q, nib_d;
    logic [DIGITS-1:0]    en_q, en_d;
    logic                 dp_q, dp_d;
    logic                 fd_q, fd_d;

    // Combinational helpers
    logic                 boundary;
    logic                 zero_above;
    logic [DIGITS-1:0]    blank_vec;
    logic                 lit;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q + CNT_W'(1);
        shadow_d    = shadow_q;
        shadow_dp_d = shadow_dp_q;
        buf_d       = buf_q;
        buf_dp_d    = buf_dp_q;
        pending_d   = pending_q;
        zero_above  = 1'b1;
        blank_vec   = '0;

        // The last SHOW cycle of the last digit is the frame boundary.
        boundary = (state_q == ST_SHOW) && (idx_q == IDX_LAST) && (cnt_q == SHOW_LAST);

        unique case (state_q)
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = ST_SHOW;
                    cnt_d   = '0;
                end
            end
            ST_SHOW: begin
                if (cnt_q == SHOW_LAST) begin
                    state_d = ST_GAP;
                    cnt_d   = '0;
                    idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
                end
            end
            default: ;
        endcase

        if (load) begin
            buf_d     = value;
            buf_dp_d  = dp_in;
            pending_d = 1'b1;
        end

        // A load coinciding with the boundary bypasses the buffer entirely,
        // so it is never left pending for a whole extra frame.
        if (boundary) begin
            if (load) begin
                shadow_d    = value;
                shadow_dp_d = dp_in;
                pending_d   = 1'b0;
            end else if (pending_q) begin
                shadow_d    = buf_q;
                shadow_dp_d = buf_dp_q;
                pending_d   = 1'b0;
            end
        end

        // Digit i is a leading zero when nibbles i..DIGITS-1 are all zero.
        // zero_above is a running AND, so the update must be immediate.
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_above   = zero_above & (shadow_d[4*i +: 4] == 4'h0);
            blank_vec[i] = zero_above;
        end

        // Outputs are computed from the next state so the registered outputs
        // line up with the state they describe, with no extra cycle of lag.
        lit   = (state_d == ST_SHOW) && !(lz_blank && blank_vec[idx_d]);
        nib_d = shadow_d[{idx_d, 2'b00} +: 4];
        en_d  = lit ? (DIGITS'(1) << idx_d) : '0;
        dp_d  = lit & shadow_dp_d[idx_d];
        fd_d  = (state_d == ST_SHOW) && (idx_d == IDX_LAST) && (cnt_d == SHOW_LAST);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_GAP;
            idx_q       <= '0;
            cnt_q       <= '0;
            shadow_q    <= '0;
            shadow_dp_q <= '0;
            buf_q       <= '0;
            buf_dp_q    <= '0;
            pending_q   <= 1'b0;
            nib_q       <= '0;
            en_q        <= '0;
            dp_q        <= 1'b0;
            fd_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            shadow_q    <= shadow_d;
            shadow_dp_q <= shadow_dp_d;
            buf_q       <= buf_d;
            buf_dp_q    <= buf_dp_d;
            pending_q   <= pending_d;
            nib_q       <= nib_d;
            en_q        <= en_d;
            dp_q        <= dp_d;
            fd_q        <= fd_d;
        end
    end

    assign {c3, c2, c1, c0} = nib_q;
    assign dig_en           = en_q;
    assign dp               = dp_q;
    assign frame_done       = fd_q;
    assign pending          = pending_q;

endmodule
